cache_line_refill_ctrl: RTL

- Memory-side responder for the data cache's line-fill/write-back handshake.
- On a miss it fetches the 16-byte line from memory in four 32-bit beats and presents it on `cache_write_load_data` with `cache_load_enable` held.
- If the cache requests eviction via `cache_save_data`, it writes the dirty victim line back in four beats, acknowledges with `cache_save_ready`, then waits for `cache_load_complate`.
- Sits between the cache and the system memory bus.

---
 rtl/cache_line_refill_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_line_refill_ctrl.sv
// Cache line refill / victim write-back controller.
// Fetches a full cache line from memory in word-sized beats and hands it to
// the cache. If the cache asks to evict a dirty victim while the fresh line is
// being offered, the victim is written back first. After that the controller
// waits for the cache to confirm that it has stored the new line.
//
// Memory handshake (valid/ready): mem_req is the valid. A beat completes on
// any rising edge where mem_req and mem_ready are both high. mem_req, mem_we,
// mem_addr and mem_wdata are registered and do not change until that edge.
// mem_ready is ignored while mem_req is low.
module cache_line_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int WORD_BYTES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // core side
  input  logic                      miss_req,
  input  logic [ADDR_WIDTH-1:0]     miss_addr,
  input  logic [ADDR_WIDTH-1:0]     wb_addr,
  output logic                      req_ready,
  output logic                      fill_done,
  // cache side
  output logic                      cache_load_enable,
  output logic [LINE_BYTES*8-1:0]   cache_write_load_data,
  input  logic                      cache_status_ready,
  input  logic                      cache_save_data,
  input  logic [LINE_BYTES*8-1:0]   cache_write_back_data,
  output logic                      cache_save_ready,
  input  logic                      cache_load_complate,
  // memory side
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [WORD_BYTES*8-1:0]   mem_wdata,
  input  logic [WORD_BYTES*8-1:0]   mem_rdata,
  input  logic                      mem_ready,
  // FSM state, for observation only
  output logic [2:0]                dbg_state
);

  localparam int BEATS     = LINE_BYTES / WORD_BYTES;
  localparam int WORD_BITS = WORD_BYTES * 8;
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int OFF_W     = $clog2(LINE_BYTES);
  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_HANDOFF   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_SAVE_ACK  = 3'd4,
    S_WAIT_LOAD = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        beat_cnt;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    beat_fire;
  logic                    last_beat;
  logic [LINE_BITS-1:0]    line_buf;
  logic [LINE_BITS-1:0]    wb_buf;
  logic [ADDR_WIDTH-1:0]   miss_base;
  logic [ADDR_WIDTH-1:0]   wb_base;
  logic                    unused_inputs;

  // Line-aligned base addresses: offset bits inside the line are dropped.
  assign miss_base = {miss_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
  assign wb_base   = {wb_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};

  // Victim status and the in-line offset bits carry no meaning here.
  assign unused_inputs = ^{cache_status_ready, miss_addr[OFF_W-1:0], wb_addr[OFF_W-1:0]};

  assign beat_fire = mem_req & mem_ready;
  assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
  assign cnt_inc   = beat_cnt + 1'b1;

  assign cache_write_load_data = line_buf;
  assign dbg_state             = state;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and state-decoded status outputs.
  always_comb begin
    state_next        = state;
    req_ready         = 1'b0;
    fill_done         = 1'b0;
    cache_load_enable = 1'b0;
    cache_save_ready  = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (miss_req) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (beat_fire && last_beat) state_next = S_HANDOFF;
      end
      S_HANDOFF: begin
        cache_load_enable = 1'b1;
        // An eviction request wins over completion in the same cycle.
        if (cache_save_data)          state_next = S_WRITEBACK;
        else if (cache_load_complate) state_next = S_DONE;
      end
      S_WRITEBACK: begin
        cache_load_enable = 1'b1;
        if (beat_fire && last_beat) state_next = S_SAVE_ACK;
      end
      S_SAVE_ACK: begin
        cache_load_enable = 1'b1;
        cache_save_ready  = 1'b1;
        state_next        = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: begin
        // A second eviction request here is ignored: one write-back per miss.
        cache_load_enable = 1'b1;
        if (cache_load_complate) state_next = S_DONE;
      end
      S_DONE: begin
        fill_done  = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Beat issue, beat counter and the two line buffers. The refill buffer is
  // only written during FETCH, so it is frozen while the cache holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt  <= '0;
      line_buf  <= '0;
      wb_buf    <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (miss_req) begin
            beat_cnt  <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= miss_base;
            mem_wdata <= '0;
          end
        end
        S_FETCH: begin
          if (beat_fire) begin
            line_buf[beat_cnt*WORD_BITS +: WORD_BITS] <= mem_rdata;
            if (last_beat) begin
              mem_req  <= 1'b0;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= cnt_inc;
              mem_addr <= mem_addr + ADDR_WIDTH'(WORD_BYTES);
            end
          end
        end
        S_HANDOFF: begin
          if (cache_save_data) begin
            wb_buf    <= cache_write_back_data;
            beat_cnt  <= '0;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= wb_base;
            mem_wdata <= cache_write_back_data[WORD_BITS-1:0];
          end
        end
        S_WRITEBACK: begin
          if (beat_fire) begin
            if (last_beat) begin
              mem_req   <= 1'b0;
              mem_we    <= 1'b0;
              mem_wdata <= '0;
              beat_cnt  <= '0;
            end else begin
              beat_cnt  <= cnt_inc;
              mem_addr  <= mem_addr + ADDR_WIDTH'(WORD_BYTES);
              mem_wdata <= wb_buf[cnt_inc*WORD_BITS +: WORD_BITS];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
